bram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one dual-port block RAM (write port A, read port B, one clock) between the core's data-memory path (requester 0) and the program loader/debug path (requester 1). Writes and reads are arbitrated independently, each with its own round-robin pointer, so one write and one read can proceed per cycle. The block returns read data with a fixed one-cycle latency. A same-cycle write/read to the same address is forwarded, giving write-first semantics.

---
 rtl/bram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a shared dual-port BRAM: independent round-robin
// arbitration of the write port (A) and read port (B), with write-first forwarding.
module bram_port_arbiter #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 1024,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_valid,
  input  logic                 m0_we,
  input  logic [AW-1:0]        m0_addr,
  input  logic [RAM_WIDTH-1:0] m0_wdata,
  output logic                 m0_ready,
  output logic                 m0_rvalid,
  input  logic                 m1_valid,
  input  logic                 m1_we,
  input  logic [AW-1:0]        m1_addr,
  input  logic [RAM_WIDTH-1:0] m1_wdata,
  output logic                 m1_ready,
  output logic                 m1_rvalid,
  output logic [RAM_WIDTH-1:0] rdata,
  output logic                 mem_wr_ena,
  output logic [AW-1:0]        mem_addra,
  output logic [RAM_WIDTH-1:0] mem_dina,
  output logic                 mem_rd_enb,
  output logic [AW-1:0]        mem_addrb,
  input  logic [RAM_WIDTH-1:0] mem_doutb
);

  // Grant vector {g1,g0}: a lone candidate wins, otherwise the pointer decides.
  function automatic logic [1:0] rr_grant(input logic c0, input logic c1, input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    if (c0 && c1) begin
      if (ptr) begin
        g = 2'b10;
      end else begin
        g = 2'b01;
      end
    end else begin
      g = {c1, c0};
    end
    return g;
  endfunction

  // After granting requester i the pointer moves to the other requester.
  function automatic logic rr_next(input logic [1:0] g, input logic ptr);
    logic n;
    if (g[0]) begin
      n = 1'b1;
    end else if (g[1]) begin
      n = 1'b0;
    end else begin
      n = ptr;
    end
    return n;
  endfunction

  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 rpend_q, rpend_d;
  logic                 rsel_q, rsel_d;
  logic                 byp_q, byp_d;
  logic [RAM_WIDTH-1:0] byp_data_q, byp_data_d;

  logic [1:0]           wr_gnt_s;
  logic [1:0]           rd_gnt_s;
  logic                 byp_hit_s;

  // Arbitration, memory strobes and next-state for both ports.
  always_comb begin
    wr_gnt_s   = 2'b00;
    rd_gnt_s   = 2'b00;
    byp_hit_s  = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rpend_d    = 1'b0;
    rsel_d     = rsel_q;
    byp_d      = 1'b0;
    byp_data_d = byp_data_q;
    mem_wr_ena = 1'b0;
    mem_addra  = m0_addr;
    mem_dina   = m0_wdata;
    mem_rd_enb = 1'b0;
    mem_addrb  = m0_addr;

    if (rst) begin
      wr_gnt_s = 2'b00;
      rd_gnt_s = 2'b00;
    end else begin
      wr_gnt_s = rr_grant(m0_valid & m0_we, m1_valid & m1_we, wr_ptr_q);
      rd_gnt_s = rr_grant(m0_valid & ~m0_we, m1_valid & ~m1_we, rd_ptr_q);
    end

    if (wr_gnt_s[1]) begin
      mem_addra = m1_addr;
      mem_dina  = m1_wdata;
    end else begin
      mem_addra = m0_addr;
      mem_dina  = m0_wdata;
    end

    if (rd_gnt_s[1]) begin
      mem_addrb = m1_addr;
    end else begin
      mem_addrb = m0_addr;
    end

    mem_wr_ena = |wr_gnt_s;
    mem_rd_enb = |rd_gnt_s;
    wr_ptr_d   = rr_next(wr_gnt_s, wr_ptr_q);
    rd_ptr_d   = rr_next(rd_gnt_s, rd_ptr_q);

    // The RAM returns old data on a same-address collision, so capture the write.
    byp_hit_s = mem_wr_ena & mem_rd_enb & (mem_addra == mem_addrb);
    if (byp_hit_s) begin
      byp_data_d = mem_dina;
    end else begin
      byp_data_d = byp_data_q;
    end

    if (mem_rd_enb) begin
      rpend_d = 1'b1;
      rsel_d  = rd_gnt_s[1];
      byp_d   = byp_hit_s;
    end else begin
      rpend_d = 1'b0;
      rsel_d  = rsel_q;
      byp_d   = 1'b0;
    end
  end

  assign m0_ready  = wr_gnt_s[0] | rd_gnt_s[0];
  assign m1_ready  = wr_gnt_s[1] | rd_gnt_s[1];
  assign m0_rvalid = rpend_q & ~rsel_q;
  assign m1_rvalid = rpend_q & rsel_q;
  assign rdata     = byp_q ? byp_data_q : mem_doutb;

  // Pointer and read-response state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rpend_q    <= 1'b0;
      rsel_q     <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= {RAM_WIDTH{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rpend_q    <= rpend_d;
      rsel_q     <= rsel_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a behavioural
// read-old-data dual-port RAM attached to the memory ports.
module tb_bram_port_arbiter;

  localparam int W  = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_clr;
  logic          m0_valid, m0_we, m1_valid, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [W-1:0]  m0_wdata, m1_wdata;
  logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [W-1:0]  rdata;
  logic          mem_wr_ena, mem_rd_enb;
  logic [AW-1:0] mem_addra, mem_addrb;
  logic [W-1:0]  mem_dina, mem_doutb;
  logic [W-1:0]  mem [0:1023];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .mem_wr_ena(mem_wr_ena), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_rd_enb(mem_rd_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
  );

  // Behavioural BRAM: registered read returning the pre-write contents.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem_doutb <= 32'h0;
    end else begin
      if (mem_wr_ena) mem[mem_addra] <= mem_dina;
      if (mem_rd_enb) mem_doutb <= mem[mem_addrb];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    drv1(1'b0, 1'b0, 10'd0, 32'h0);
    step();
    step();
    mem_clr = 1'b0;

    // Reset state: no responses, no grants while rst is high.
    drv0(1'b1, 1'b0, 10'd9, 32'h0);
    #1;
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_rd_enb", {31'd0, mem_rd_enb}, 32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    step();
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    rst = 1'b0;
    step();

    // Write then read back through the RAM.
    drv0(1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    #1;
    chk("t1_wr_ready", {31'd0, m0_ready}, 32'd1);
    chk("t1_wr_ena", {31'd0, mem_wr_ena}, 32'd1);
    chk("t1_addra", {22'd0, mem_addra}, 32'd5);
    chk("t1_dina", mem_dina, 32'hDEADBEEF);
    step();
    drv0(1'b1, 1'b0, 10'd5, 32'h0);
    #1;
    chk("t1_rd_ready", {31'd0, m0_ready}, 32'd1);
    chk("t1_rd_enb", {31'd0, mem_rd_enb}, 32'd1);
    chk("t1_addrb", {22'd0, mem_addrb}, 32'd5);
    step();
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    chk("t1_rvalid0", {31'd0, m0_rvalid}, 32'd1);
    chk("t1_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    step();
    chk("t1_rvalid0_off", {31'd0, m0_rvalid}, 32'd0);

    // Write contention alternates m0, m1, m0, m1.
    do_reset();
    drv0(1'b1, 1'b1, 10'd1, 32'h11);
    drv1(1'b1, 1'b1, 10'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_m0_ready_%0d", i), {31'd0, m0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2_m1_ready_%0d", i), {31'd0, m1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
    end
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    drv1(1'b0, 1'b0, 10'd0, 32'h0);
    step();
    drv0(1'b1, 1'b0, 10'd1, 32'h0);
    step();
    drv0(1'b1, 1'b0, 10'd2, 32'h0);
    #1;
    chk("t2_addr1", rdata, 32'h11);
    step();
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    chk("t2_addr2", rdata, 32'h22);

    // Read contention: m0 first, then m1, responses never overlap.
    drv0(1'b1, 1'b1, 10'd3, 32'h33);
    step();
    drv0(1'b1, 1'b1, 10'd4, 32'h44);
    step();
    do_reset();
    drv0(1'b1, 1'b0, 10'd3, 32'h0);
    drv1(1'b1, 1'b0, 10'd4, 32'h0);
    #1;
    chk("t3_c0_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t3_c0_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("t3_c0_addrb", {22'd0, mem_addrb}, 32'd3);
    step();
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    chk("t3_c1_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("t3_c1_addrb", {22'd0, mem_addrb}, 32'd4);
    chk("t3_c1_rvalid0", {31'd0, m0_rvalid}, 32'd1);
    chk("t3_c1_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    chk("t3_c1_rdata", rdata, 32'h33);
    step();
    drv1(1'b0, 1'b0, 10'd0, 32'h0);
    chk("t3_c2_rvalid0", {31'd0, m0_rvalid}, 32'd0);
    chk("t3_c2_rvalid1", {31'd0, m1_rvalid}, 32'd1);
    chk("t3_c2_rdata", rdata, 32'h44);

    // Same-cycle write/read to one address is forwarded (RAM returns old 0).
    drv1(1'b1, 1'b1, 10'd7, 32'hCAFE0001);
    drv0(1'b1, 1'b0, 10'd7, 32'h0);
    #1;
    chk("t4_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t4_m1_ready", {31'd0, m1_ready}, 32'd1);
    step();
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    drv1(1'b0, 1'b0, 10'd0, 32'h0);
    chk("t4_rvalid0", {31'd0, m0_rvalid}, 32'd1);
    chk("t4_bypass_rdata", rdata, 32'hCAFE0001);
    drv0(1'b1, 1'b0, 10'd7, 32'h0);
    step();
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    chk("t4_ram_rdata", rdata, 32'hCAFE0001);

    // Read issued in the cycle reset asserts gives no response.
    drv0(1'b1, 1'b0, 10'd9, 32'h0);
    rst = 1'b1;
    #1;
    chk("t5_m0_ready", {31'd0, m0_ready}, 32'd0);
    step();
    rst = 1'b0;
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    chk("t5_rvalid0", {31'd0, m0_rvalid}, 32'd0);
    chk("t5_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    drv0(1'b1, 1'b1, 10'd10, 32'hA);
    drv1(1'b1, 1'b1, 10'd11, 32'hB);
    #1;
    chk("t5_wr_m0_first", {31'd0, m0_ready}, 32'd1);
    chk("t5_wr_m1_wait", {31'd0, m1_ready}, 32'd0);
    step();
    drv0(1'b1, 1'b0, 10'd10, 32'h0);
    drv1(1'b1, 1'b0, 10'd11, 32'h0);
    #1;
    chk("t5_rd_m0_first", {31'd0, m0_ready}, 32'd1);
    chk("t5_rd_m1_wait", {31'd0, m1_ready}, 32'd0);
    step();

    // After a grant to m1 and idle cycles the pointer stays on m0.
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    chk("t6_m1_granted", {31'd0, m1_ready}, 32'd1);
    step();
    drv1(1'b0, 1'b0, 10'd0, 32'h0);
    step();
    step();
    step();
    drv0(1'b1, 1'b0, 10'd1, 32'h0);
    drv1(1'b1, 1'b0, 10'd2, 32'h0);
    #1;
    chk("t6_m0_first", {31'd0, m0_ready}, 32'd1);
    chk("t6_m1_wait", {31'd0, m1_ready}, 32'd0);
    step();
    drv0(1'b0, 1'b0, 10'd0, 32'h0);
    drv1(1'b0, 1'b0, 10'd0, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
